// File: rtl/npc_bp_pkg.sv
// Shared encodings for the next-PC block: NPCOp values as they arrive from the EX
// stage, and the 2-bit saturating-counter constants used by the BTB.
package npc_bp_pkg;

  // NPCOp encodings; these must stay in step with the decoder's control encoding.
  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JALR   = 3'b100
  } npc_op_e;

  // Counter states: strongly/weakly not-taken, weakly/strongly taken.
  localparam logic [1:0] NPC_CNT_SNT = 2'd0;
  localparam logic [1:0] NPC_CNT_WNT = 2'd1;
  localparam logic [1:0] NPC_CNT_WT  = 2'd2;
  localparam logic [1:0] NPC_CNT_ST  = 2'd3;

  // Saturating step of a 2-bit counter towards the resolved direction.
  function automatic logic [1:0] npc_cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == NPC_CNT_ST) ? NPC_CNT_ST : cnt + 2'd1;
    end
    return (cnt == NPC_CNT_SNT) ? NPC_CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: asynchronous lookup on the fetch PC and one
// update port driven by the control instruction resolving in EX. The update port
// applies the counter/allocation rules itself so the top only forwards EX results.
module npc_btb import npc_bp_pkg::*; #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_taken_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [2:0]      upd_op_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q  [BTB_ENTRIES];
  logic [1:0]       cnt_q    [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]  target_q [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  logic             cnt_we, data_we;
  logic [1:0]       cnt_d;

  // Instructions are word aligned, so the two LSBs never take part in index or tag.
  logic unused_lsb;
  assign unused_lsb = ^{rd_pc_i[1:0], upd_pc_i[1:0]};

  assign rd_idx = rd_pc_i[IDX_W+1:2];
  assign rd_tag = rd_pc_i[XLEN-1:IDX_W+2];
  assign wr_idx = upd_pc_i[IDX_W+1:2];
  assign wr_tag = upd_pc_i[XLEN-1:IDX_W+2];

  assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken_o  = rd_hit && cnt_q[rd_idx][1];
  assign rd_target_o = target_q[rd_idx];
  assign wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Decide what the resolving instruction writes: counter/valid and/or tag/target.
  always_comb begin
    cnt_we  = 1'b0;
    data_we = 1'b0;
    cnt_d   = cnt_q[wr_idx];
    if (upd_valid_i) begin
      case (upd_op_i)
        NPC_JUMP, NPC_JALR: begin
          cnt_we  = 1'b1;
          data_we = 1'b1;
          cnt_d   = NPC_CNT_ST;
        end
        NPC_BRANCH: begin
          if (wr_hit) begin
            cnt_we  = 1'b1;
            data_we = upd_taken_i;
            cnt_d   = npc_cnt_next(cnt_q[wr_idx], upd_taken_i);
          end else if (upd_taken_i) begin
            // Not-taken misses are not worth an entry; taken ones start weakly taken.
            cnt_we  = 1'b1;
            data_we = 1'b1;
            cnt_d   = NPC_CNT_WT;
          end
        end
        default: ;
      endcase
    end
  end

  // Valid bits and counters: cleared by reset, which also blocks any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= NPC_CNT_SNT;
      end
    end else if (cnt_we) begin
      valid_q[wr_idx] <= 1'b1;
      cnt_q[wr_idx]   <= cnt_d;
    end
  end

  // Tag and target payload; no reset needed since valid gates every use.
  always_ff @(posedge clk) begin
    if (!rst && data_we) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= upd_target_i;
    end
  end

endmodule

// File: rtl/npc_bp.sv
// Next-PC generator: fetch PC register, branch prediction and EX-stage mispredict
// redirect. Build with NPC_BTB_EN defined to get the BTB predictor; without it the
// block always predicts fall-through (pc+4) and keeps the same ports.
module npc_bp import npc_bp_pkg::*; #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [2:0]      ex_npcop_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            flush_o
);

  if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("BTB_ENTRIES must be a power of two and at least 2");
  end

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4, fix_pc;
  logic            act_taken, mispredict;

  assign pc_o     = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);

`ifdef NPC_BTB_EN
  logic            btb_taken;
  logic [XLEN-1:0] btb_target;

  npc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .rd_pc_i      (pc_q),
    .rd_taken_o   (btb_taken),
    .rd_target_o  (btb_target),
    .upd_valid_i  (ex_valid_i),
    .upd_pc_i     (ex_pc_i),
    .upd_op_i     (ex_npcop_i),
    .upd_taken_i  (ex_taken_i),
    .upd_target_i (ex_target_i)
  );

  assign pred_taken_o  = btb_taken;
  assign pred_target_o = btb_taken ? btb_target : pc_plus4;
`else
  assign pred_taken_o  = 1'b0;
  assign pred_target_o = pc_plus4;
`endif

  // Actual direction of the instruction resolving in EX; unknown ops fall through.
  always_comb begin
    case (ex_npcop_i)
      NPC_BRANCH:         act_taken = ex_taken_i;
      NPC_JUMP, NPC_JALR: act_taken = 1'b1;
      default:            act_taken = 1'b0;
    endcase
  end

  assign mispredict = ex_valid_i && !rst &&
                      ((act_taken != ex_pred_taken_i) ||
                       (act_taken && (ex_target_i != ex_pred_target_i)));
  assign flush_o    = mispredict;
  assign fix_pc     = act_taken ? ex_target_i : ex_pc_i + XLEN'(4);

  // Next fetch address: a redirect must win over a stall or the fix would be lost.
  always_comb begin
    if (mispredict) begin
      pc_d = fix_pc;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_target_o;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_npc_bp.sv
// Bench for npc_bp: directed scenarios plus a randomized run, all checked each cycle
// against a behavioural model (table of entries keyed by index, PC tracked directly).
module tb_npc_bp;
  import npc_bp_pkg::*;

  localparam int          ENT    = 16;
  localparam int          IDX_W  = $clog2(ENT);
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef NPC_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  typedef struct packed {
    logic        r, st, v;
    logic [31:0] pc;
    logic [2:0]  op;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0;
  logic        ex_valid = 1'b0, ex_taken = 1'b0, ex_ptaken = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_ptarget = '0;
  logic [2:0]  ex_op = 3'b000;
  logic [31:0] pc_o, pred_target_o;
  logic        pred_taken_o, flush_o;

  int n_run = 0;
  int n_fail = 0;

  // Model state
  logic [31:0] m_pc;
  bit          m_v   [ENT];
  logic [31:0] m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_cnt [ENT];

  npc_bp #(
    .XLEN        (32),
    .BTB_ENTRIES (ENT),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .pc_o             (pc_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .ex_valid_i       (ex_valid),
    .ex_pc_i          (ex_pc),
    .ex_npcop_i       (ex_op),
    .ex_taken_i       (ex_taken),
    .ex_target_i      (ex_target),
    .ex_pred_taken_i  (ex_ptaken),
    .ex_pred_target_i (ex_ptarget),
    .flush_o          (flush_o)
  );

  always #5 clk = ~clk;

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / 4) % ENT;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (2 + IDX_W);
  endfunction

  function automatic bit m_pt();
    int unsigned k = idx_of(m_pc);
    return BTB_ON && m_v[k] && (m_tag[k] == tag_of(m_pc)) && (m_cnt[k] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt();
    return m_pt() ? m_tgt[idx_of(m_pc)] : m_pc + 32'd4;
  endfunction

  function automatic bit m_act();
    if (ex_op == NPC_BRANCH) return ex_taken;
    return (ex_op == NPC_JUMP) || (ex_op == NPC_JALR);
  endfunction

  function automatic bit m_fl();
    return ex_valid && !rst &&
           ((m_act() != ex_ptaken) || (m_act() && (ex_target != ex_ptarget)));
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void m_advance();
    logic [31:0] nxt;
    int unsigned k;
    bit          hit;
    if (rst) nxt = RST_PC;
    else if (m_fl()) nxt = m_act() ? ex_target : ex_pc + 32'd4;
    else if (stall) nxt = m_pc;
    else nxt = m_ptgt();
    if (rst) begin
      for (int j = 0; j < ENT; j++) begin
        m_v[j] = 1'b0;
        m_cnt[j] = 0;
      end
    end else if (BTB_ON && ex_valid) begin
      k = idx_of(ex_pc);
      hit = m_v[k] && (m_tag[k] == tag_of(ex_pc));
      if (ex_op == NPC_JUMP || ex_op == NPC_JALR) begin
        m_v[k] = 1'b1; m_tag[k] = tag_of(ex_pc); m_tgt[k] = ex_target; m_cnt[k] = 3;
      end else if (ex_op == NPC_BRANCH) begin
        if (hit && ex_taken) begin
          m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
          m_tgt[k] = ex_target;
        end else if (hit) begin
          m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
        end else if (ex_taken) begin
          m_v[k] = 1'b1; m_tag[k] = tag_of(ex_pc); m_tgt[k] = ex_target; m_cnt[k] = 2;
        end
      end
    end
    m_pc = nxt;
  endfunction

  function automatic stim_t mk(input bit r, input bit st, input bit v, input logic [31:0] pc,
                               input logic [2:0] op, input bit tk, input logic [31:0] tgt,
                               input bit ptk, input logic [31:0] ptgt);
    stim_t s;
    s.r = r; s.st = st; s.v = v; s.pc = pc; s.op = op;
    s.tk = tk; s.tgt = tgt; s.ptk = ptk; s.ptgt = ptgt;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 32'h0, NPC_PLUS4, 0, 32'h0, 0, 32'h0);
  endfunction

  // A fall-through op that was predicted taken: forces fetch to address a.
  function automatic stim_t redir(input logic [31:0] a);
    return mk(0, 0, 1, a - 32'd4, NPC_PLUS4, 0, 32'h0, 1, 32'hDEAD_BEE0);
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clk);
    rst = s.r; stall = s.st; ex_valid = s.v; ex_pc = s.pc; ex_op = s.op;
    ex_taken = s.tk; ex_target = s.tgt; ex_ptaken = s.ptk; ex_ptarget = s.ptgt;
    #1;
  endtask

  task automatic adv();
    m_advance();
    @(posedge clk);
  endtask

  task automatic test_reset();
    stim_t q[$];
    q.push_back(mk(1, 0, 1, 32'h70, NPC_JUMP, 1, 32'h90, 0, 32'h0));
    q.push_back(mk(1, 0, 0, 32'h0, NPC_PLUS4, 0, 32'h0, 0, 32'h0));
    for (int j = 0; j < 4; j++) q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]);
      n_run++;
      if ({pc_o, pred_taken_o, pred_target_o, flush_o} !== {m_pc, m_pt(), m_ptgt(), m_fl()}) begin
        n_fail++;
        $display("FAIL reset[%0d] got pc=%h pt=%b tgt=%h fl=%b want pc=%h pt=%b tgt=%h fl=%b",
                 i, pc_o, pred_taken_o, pred_target_o, flush_o, m_pc, m_pt(), m_ptgt(), m_fl());
      end
      if (i == 1) begin
        n_run++;
        if ({pc_o, pred_taken_o, pred_target_o, flush_o} !== {RST_PC, 1'b0, RST_PC + 32'd4, 1'b0}) begin
          n_fail++;
          $display("FAIL reset_state got pc=%h pt=%b tgt=%h fl=%b want pc=%h pt=0 tgt=%h fl=0",
                   pc_o, pred_taken_o, pred_target_o, flush_o, RST_PC, RST_PC + 32'd4);
        end
      end
      if (i >= 2) begin
        n_run++;
        if (pc_o !== 32'(4 * (i - 2))) begin
          n_fail++;
          $display("FAIL reset_seq[%0d] got pc=%h want %h", i, pc_o, 32'(4 * (i - 2)));
        end
      end
      adv();
    end
  endtask

  task automatic test_stall();
    stim_t q[$];
    q.push_back(mk(1, 0, 0, 32'h0, NPC_PLUS4, 0, 32'h0, 0, 32'h0));
    q.push_back(idle());
    q.push_back(idle());
    for (int j = 0; j < 3; j++) q.push_back(mk(0, 1, 0, 32'h0, NPC_PLUS4, 0, 32'h0, 0, 32'h0));
    q.push_back(idle());
    q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]);
      n_run++;
      if ({pc_o, pred_taken_o, pred_target_o, flush_o} !== {m_pc, m_pt(), m_ptgt(), m_fl()}) begin
        n_fail++;
        $display("FAIL stall[%0d] got pc=%h pt=%b tgt=%h fl=%b want pc=%h pt=%b tgt=%h fl=%b",
                 i, pc_o, pred_taken_o, pred_target_o, flush_o, m_pc, m_pt(), m_ptgt(), m_fl());
      end
      if (i >= 3) begin
        n_run++;
        if (pc_o !== ((i == 7) ? 32'hC : 32'h8)) begin
          n_fail++;
          $display("FAIL stall_pc[%0d] got pc=%h want %h", i, pc_o, (i == 7) ? 32'hC : 32'h8);
        end
      end
      adv();
    end
  endtask

  task automatic test_learn();
    stim_t q[$];
    q.push_back(mk(0, 0, 1, 32'h10, NPC_BRANCH, 1, 32'h40, 0, 32'h14));
    q.push_back(idle());
    q.push_back(redir(32'h10));
    q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]);
      n_run++;
      if ({pc_o, pred_taken_o, pred_target_o, flush_o} !== {m_pc, m_pt(), m_ptgt(), m_fl()}) begin
        n_fail++;
        $display("FAIL learn[%0d] got pc=%h pt=%b tgt=%h fl=%b want pc=%h pt=%b tgt=%h fl=%b",
                 i, pc_o, pred_taken_o, pred_target_o, flush_o, m_pc, m_pt(), m_ptgt(), m_fl());
      end
      if (i == 0) begin
        n_run++;
        if (flush_o !== 1'b1) begin
          n_fail++;
          $display("FAIL learn_flush got %b want 1", flush_o);
        end
      end
      if (i == 1) begin
        n_run++;
        if (pc_o !== 32'h40) begin
          n_fail++;
          $display("FAIL learn_redirect got pc=%h want 00000040", pc_o);
        end
      end
      if (i == 3) begin
        n_run++;
        if ({pred_taken_o, pred_target_o} !== {BTB_ON, BTB_ON ? 32'h40 : 32'h14}) begin
          n_fail++;
          $display("FAIL learn_pred got pt=%b tgt=%h want pt=%b tgt=%h", pred_taken_o,
                   pred_target_o, BTB_ON, BTB_ON ? 32'h40 : 32'h14);
        end
      end
      adv();
    end
  endtask

  task automatic test_hysteresis();
    stim_t q[$];
    q.push_back(mk(0, 0, 1, 32'h10, NPC_BRANCH, 0, 32'h40, 1, 32'h40));
    q.push_back(idle());
    q.push_back(redir(32'h10));
    q.push_back(idle());
    q.push_back(mk(0, 0, 1, 32'h10, NPC_BRANCH, 1, 32'h40, 0, 32'h14));
    q.push_back(mk(0, 0, 1, 32'h10, NPC_BRANCH, 1, 32'h40, 1, 32'h40));
    q.push_back(mk(0, 0, 1, 32'h10, NPC_BRANCH, 0, 32'h40, 0, 32'h14));
    q.push_back(redir(32'h10));
    q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]);
      n_run++;
      if ({pc_o, pred_taken_o, pred_target_o, flush_o} !== {m_pc, m_pt(), m_ptgt(), m_fl()}) begin
        n_fail++;
        $display("FAIL hyst[%0d] got pc=%h pt=%b tgt=%h fl=%b want pc=%h pt=%b tgt=%h fl=%b",
                 i, pc_o, pred_taken_o, pred_target_o, flush_o, m_pc, m_pt(), m_ptgt(), m_fl());
      end
      if (i == 0) begin
        n_run++;
        if (flush_o !== 1'b1) begin
          n_fail++;
          $display("FAIL hyst_flush got %b want 1", flush_o);
        end
      end
      if (i == 1) begin
        n_run++;
        if (pc_o !== 32'h14) begin
          n_fail++;
          $display("FAIL hyst_fix got pc=%h want 00000014", pc_o);
        end
      end
      if (i == 3 || i == 8) begin
        n_run++;
        if ((pc_o !== 32'h10) || (pred_taken_o !== ((i == 8) && BTB_ON))) begin
          n_fail++;
          $display("FAIL hyst_pred[%0d] got pc=%h pt=%b want pc=00000010 pt=%b", i, pc_o,
                   pred_taken_o, (i == 8) && BTB_ON);
        end
      end
      adv();
    end
  endtask

  task automatic test_alias_jalr();
    stim_t q[$];
    q.push_back(redir(32'h50));
    q.push_back(idle());
    q.push_back(mk(0, 1, 1, 32'h20, NPC_JALR, 0, 32'h80, 1, 32'h60));
    q.push_back(mk(0, 1, 0, 32'h0, NPC_PLUS4, 0, 32'h0, 0, 32'h0));
    q.push_back(redir(32'h20));
    q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]);
      n_run++;
      if ({pc_o, pred_taken_o, pred_target_o, flush_o} !== {m_pc, m_pt(), m_ptgt(), m_fl()}) begin
        n_fail++;
        $display("FAIL alias_jalr[%0d] got pc=%h pt=%b tgt=%h fl=%b want pc=%h pt=%b tgt=%h fl=%b",
                 i, pc_o, pred_taken_o, pred_target_o, flush_o, m_pc, m_pt(), m_ptgt(), m_fl());
      end
      if (i == 1) begin
        n_run++;
        if ({pc_o, pred_taken_o, pred_target_o} !== {32'h50, 1'b0, 32'h54}) begin
          n_fail++;
          $display("FAIL alias got pc=%h pt=%b tgt=%h want pc=00000050 pt=0 tgt=00000054",
                   pc_o, pred_taken_o, pred_target_o);
        end
      end
      if (i == 2) begin
        n_run++;
        if (flush_o !== 1'b1) begin
          n_fail++;
          $display("FAIL jalr_flush got %b want 1", flush_o);
        end
      end
      if (i == 3) begin
        n_run++;
        if (pc_o !== 32'h80) begin
          n_fail++;
          $display("FAIL jalr_fix got pc=%h want 00000080", pc_o);
        end
      end
      if (i == 5) begin
        n_run++;
        if ({pred_taken_o, pred_target_o} !== {BTB_ON, BTB_ON ? 32'h80 : 32'h24}) begin
          n_fail++;
          $display("FAIL jalr_pred got pt=%b tgt=%h want pt=%b tgt=%h", pred_taken_o,
                   pred_target_o, BTB_ON, BTB_ON ? 32'h80 : 32'h24);
        end
      end
      adv();
    end
  endtask

  task automatic test_same_edge_wrap();
    stim_t q[$];
    q.push_back(redir(32'h30));
    q.push_back(mk(0, 0, 1, 32'h30, NPC_JUMP, 0, 32'hA0, 1, 32'hA0));
    q.push_back(redir(32'h30));
    q.push_back(idle());
    q.push_back(mk(0, 0, 1, 32'hFFFF_FFF8, NPC_PLUS4, 0, 32'h0, 1, 32'h0));
    q.push_back(idle());
    q.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, NPC_PLUS4, 0, 32'h0, 1, 32'h0));
    q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]);
      n_run++;
      if ({pc_o, pred_taken_o, pred_target_o, flush_o} !== {m_pc, m_pt(), m_ptgt(), m_fl()}) begin
        n_fail++;
        $display("FAIL edge_wrap[%0d] got pc=%h pt=%b tgt=%h fl=%b want pc=%h pt=%b tgt=%h fl=%b",
                 i, pc_o, pred_taken_o, pred_target_o, flush_o, m_pc, m_pt(), m_ptgt(), m_fl());
      end
      if (i == 1) begin
        n_run++;
        if ({pc_o, pred_taken_o, flush_o} !== {32'h30, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL same_edge got pc=%h pt=%b fl=%b want pc=00000030 pt=0 fl=0", pc_o,
                   pred_taken_o, flush_o);
        end
      end
      if (i == 3) begin
        n_run++;
        if ({pred_taken_o, pred_target_o} !== {BTB_ON, BTB_ON ? 32'hA0 : 32'h34}) begin
          n_fail++;
          $display("FAIL same_edge_next got pt=%b tgt=%h want pt=%b tgt=%h", pred_taken_o,
                   pred_target_o, BTB_ON, BTB_ON ? 32'hA0 : 32'h34);
        end
      end
      if (i == 5) begin
        n_run++;
        if ({pc_o, pred_target_o} !== {32'hFFFF_FFFC, 32'h0}) begin
          n_fail++;
          $display("FAIL wrap_pred got pc=%h tgt=%h want pc=fffffffc tgt=00000000", pc_o,
                   pred_target_o);
        end
      end
      if (i == 7) begin
        n_run++;
        if (pc_o !== 32'h0) begin
          n_fail++;
          $display("FAIL wrap_fix got pc=%h want 00000000", pc_o);
        end
      end
      adv();
    end
  endtask

  task automatic test_reset_redirect();
    stim_t q[$];
    q.push_back(mk(1, 1, 1, 32'h70, NPC_JUMP, 1, 32'h90, 0, 32'h0));
    q.push_back(idle());
    q.push_back(redir(32'h70));
    q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]);
      n_run++;
      if ({pc_o, pred_taken_o, pred_target_o, flush_o} !== {m_pc, m_pt(), m_ptgt(), m_fl()}) begin
        n_fail++;
        $display("FAIL rst_redir[%0d] got pc=%h pt=%b tgt=%h fl=%b want pc=%h pt=%b tgt=%h fl=%b",
                 i, pc_o, pred_taken_o, pred_target_o, flush_o, m_pc, m_pt(), m_ptgt(), m_fl());
      end
      if (i == 0) begin
        n_run++;
        if (flush_o !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_flush got %b want 0", flush_o);
        end
      end
      if (i == 1) begin
        n_run++;
        if (pc_o !== RST_PC) begin
          n_fail++;
          $display("FAIL rst_wins got pc=%h want %h", pc_o, RST_PC);
        end
      end
      if (i == 3) begin
        n_run++;
        if ({pc_o, pred_taken_o} !== {32'h70, 1'b0}) begin
          n_fail++;
          $display("FAIL rst_no_write got pc=%h pt=%b want pc=00000070 pt=0", pc_o, pred_taken_o);
        end
      end
      adv();
    end
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  task automatic test_random();
    logic [2:0]  ops [5];
    logic [31:0] tgt;
    stim_t       s;
    ops[0] = NPC_PLUS4; ops[1] = NPC_BRANCH; ops[2] = NPC_JUMP; ops[3] = NPC_JALR;
    ops[4] = 3'b111;
    for (int i = 0; i < 600; i++) begin
      tgt = rnd_pc();
      s = mk($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
             rnd_pc(), ops[$urandom_range(0, 4)], $urandom_range(0, 1) == 1, tgt,
             $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? tgt : rnd_pc());
      if ($urandom_range(0, 3) == 0) s.pc = m_pc;
      apply(s);
      n_run++;
      if ({pc_o, pred_taken_o, pred_target_o, flush_o} !== {m_pc, m_pt(), m_ptgt(), m_fl()}) begin
        n_fail++;
        $display("FAIL random[%0d] got pc=%h pt=%b tgt=%h fl=%b want pc=%h pt=%b tgt=%h fl=%b",
                 i, pc_o, pred_taken_o, pred_target_o, flush_o, m_pc, m_pt(), m_ptgt(), m_fl());
      end
      adv();
    end
  endtask

  initial begin
    m_pc = RST_PC;
    for (int j = 0; j < ENT; j++) begin
      m_v[j] = 1'b0; m_cnt[j] = 0; m_tag[j] = '0; m_tgt[j] = '0;
    end
    test_reset();
    test_stall();
    test_learn();
    test_hysteresis();
    test_alias_jalr();
    test_same_edge_wrap();
    test_reset_redirect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
